// File: rtl/reduceron_io_pkg.sv
// Shared widths, record kinds and sequencer states for the Reduceron output-side sequencer.
package reduceron_io_pkg;

    localparam int unsigned IO_ADDR_W = 15;
    localparam int unsigned IO_DATA_W = 15;
    localparam int unsigned RES_W     = 18;
    localparam int unsigned TAG_W     = 3;

    localparam logic KIND_IO     = 1'b0;
    localparam logic KIND_RESULT = 1'b1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [IO_ADDR_W-1:0] addr;
        logic [IO_DATA_W-1:0] data;
    } io_payload_t;

    // Result records carry the 3-bit tag zero-extended into the address field.
    function automatic logic [IO_ADDR_W-1:0] tag_addr(input logic [TAG_W-1:0] tag);
        return IO_ADDR_W'(tag);
    endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Show-ahead synchronous FIFO; exposes the head and the entry behind it so the
// consumer can advance its registered view in the same cycle it pops.
module io_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 62
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           head,
    output logic [WIDTH-1:0]           next,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr_inc;

    assign rd_ptr_inc = rd_ptr + AW'(1);
    assign head       = mem[rd_ptr];
    assign next       = mem[rd_ptr_inc];
    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == CW'(0));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr_inc;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/reduceron_io_sequencer.sv
// Collects core IO writes into a timestamped queue and emits them, followed by the
// final result record, over one ready/valid stream to the host link.
module reduceron_io_sequencer
    import reduceron_io_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CYC_W = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 iowrite,
    input  logic [IO_ADDR_W-1:0] ioaddr,
    input  logic [IO_DATA_W-1:0] iowd,
    input  logic                 finish,
    input  logic [RES_W-1:0]     r,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_kind,
    output logic [IO_ADDR_W-1:0] out_addr,
    output logic [IO_DATA_W-1:0] out_data,
    output logic [CYC_W-1:0]     out_stamp,
    output logic                 done,
    output logic                 overflow,
    output logic [CYC_W-1:0]     cycles
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned PAY_W = $bits(io_payload_t);
    localparam int unsigned ENT_W = PAY_W + CYC_W;

    seq_state_t state;

    logic [ENT_W-1:0]     fifo_wdata;
    logic [ENT_W-1:0]     fifo_head;
    logic [ENT_W-1:0]     fifo_next;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    io_payload_t          head_pay;
    io_payload_t          next_pay;
    logic [CYC_W-1:0]     head_stamp;
    logic [CYC_W-1:0]     next_stamp;

    logic                 xfer;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic                 drain_done;

    logic [TAG_W-1:0]     res_tag;
    logic [IO_DATA_W-1:0] res_data;
    logic [CYC_W-1:0]     res_stamp;

    // The output register mirrors the FIFO head, so an IO record is popped only on transfer.
    assign xfer       = out_valid && out_ready;
    assign pop        = xfer && (out_kind == KIND_IO);
    assign push       = (state == RUN) && iowrite && (!fifo_full || pop);
    assign drop       = (state == RUN) && iowrite && fifo_full && !pop;
    assign drain_done = fifo_empty || ((fifo_count == CNT_W'(1)) && pop);

    assign fifo_wdata               = {ioaddr, iowd, cycles};
    assign {head_pay, head_stamp}   = fifo_head;
    assign {next_pay, next_stamp}   = fifo_next;

    io_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .head  (fifo_head),
        .next  (fifo_next),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            cycles    <= '0;
            res_tag   <= '0;
            res_data  <= '0;
            res_stamp <= '0;
            overflow  <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_kind  <= KIND_IO;
            out_addr  <= '0;
            out_data  <= '0;
            out_stamp <= '0;
        end else begin
            if (drop) overflow <= 1'b1;

            case (state)
                RUN: begin
                    if (finish) begin
                        state     <= DRAIN;
                        res_tag   <= r[TAG_W-1:0];
                        res_data  <= r[RES_W-1:TAG_W];
                        res_stamp <= cycles;
                    end else begin
                        cycles <= cycles + CYC_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_done) state <= EMIT;
                end
                EMIT: begin
                    if (xfer) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                end
            endcase

            // Output record register: hold while offered and not taken.
            if (state == EMIT) begin
                if (xfer) out_valid <= 1'b0;
            end else if ((state == DRAIN) && drain_done) begin
                out_valid <= 1'b1;
                out_kind  <= KIND_RESULT;
                out_addr  <= tag_addr(res_tag);
                out_data  <= res_data;
                out_stamp <= res_stamp;
            end else if (xfer && (fifo_count >= CNT_W'(2))) begin
                out_valid <= 1'b1;
                out_kind  <= KIND_IO;
                out_addr  <= next_pay.addr;
                out_data  <= next_pay.data;
                out_stamp <= next_stamp;
            end else if (!out_valid && !fifo_empty) begin
                out_valid <= 1'b1;
                out_kind  <= KIND_IO;
                out_addr  <= head_pay.addr;
                out_data  <= head_pay.data;
                out_stamp <= head_stamp;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reduceron_io_sequencer.sv
// Randomized scoreboard bench for reduceron_io_sequencer: a queue-based reference model
// predicts the record stream, a monitor checks each delivered record and the status outputs.
module tb_reduceron_io_sequencer;
    import reduceron_io_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CYC_W = 32;

    typedef struct packed {
        logic        kind;
        logic [14:0] addr;
        logic [14:0] data;
        logic [31:0] stamp;
    } rec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        iowrite;
    logic [14:0] ioaddr;
    logic [14:0] iowd;
    logic        finish;
    logic [17:0] r;
    logic        out_valid;
    logic        out_ready;
    logic        out_kind;
    logic [14:0] out_addr;
    logic [14:0] out_data;
    logic [31:0] out_stamp;
    logic        done;
    logic        overflow;
    logic [31:0] cycles;

    rec_t        exp_q[$];
    logic [31:0] m_cyc;
    bit          m_run;
    int          m_occ;
    bit          m_ovf;
    int          n_rx;
    rec_t        last_res;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clock = ~clock;

    reduceron_io_sequencer #(.DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .iowrite   (iowrite),
        .ioaddr    (ioaddr),
        .iowd      (iowd),
        .finish    (finish),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_kind  (out_kind),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_stamp (out_stamp),
        .done      (done),
        .overflow  (overflow),
        .cycles    (cycles)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: queue of outstanding records, capacity DEPTH, running cycle count.
    initial begin : model
        bit xfer_io;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                exp_q.delete();
                m_cyc = '0;
                m_run = 1'b1;
                m_occ = 0;
                m_ovf = 1'b0;
            end else begin
                xfer_io = out_valid && out_ready && (m_occ > 0);
                if (xfer_io) m_occ--;
                if (m_run) begin
                    if (iowrite) begin
                        if (m_occ < DEPTH) begin
                            exp_q.push_back('{kind: 1'b0, addr: ioaddr, data: iowd, stamp: m_cyc});
                            m_occ++;
                        end else begin
                            m_ovf = 1'b1;
                        end
                    end
                    if (finish) begin
                        exp_q.push_back('{kind: 1'b1, addr: 15'(r[2:0]), data: r[17:3], stamp: m_cyc});
                        m_run = 1'b0;
                    end else begin
                        m_cyc = m_cyc + 32'd1;
                    end
                end
            end
        end
    end

    // Monitor: compares delivered records, stability while stalled, status outputs.
    initial begin : monitor
        bit   hold;
        bit   done_due;
        rec_t held;
        rec_t act;
        rec_t e;
        hold     = 1'b0;
        done_due = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                hold     = 1'b0;
                done_due = 1'b0;
            end else begin
                act = '{kind: out_kind, addr: out_addr, data: out_data, stamp: out_stamp};
                check("cycles", 64'(cycles), 64'(m_cyc));
                check("overflow", 64'(overflow), 64'(m_ovf));
                if (hold) check("stable", {out_valid, act}, {1'b1, held});
                if (done_due) begin
                    check("done_after_result", 64'(done), 64'd1);
                    done_due = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_record: got 0x%0h, expected no record", act);
                    end else begin
                        e = exp_q.pop_front();
                        check("record", 64'(act), 64'(e));
                        n_rx++;
                        if (e.kind) begin
                            done_due = 1'b1;
                            last_res = act;
                        end
                    end
                end
                hold = out_valid && !out_ready;
                held = act;
            end
        end
    end

    task automatic cyc(input logic w, input logic [14:0] a, input logic [14:0] d,
                       input logic fin, input logic rdy);
        iowrite   = w;
        ioaddr    = a;
        iowd      = d;
        finish    = fin;
        out_ready = rdy;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        iowrite   = 1'b0;
        finish    = 1'b0;
        out_ready = 1'b0;
        ioaddr    = '0;
        iowd      = '0;
        r         = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_outputs", {out_valid, out_kind, out_addr, out_data, done, overflow},
              64'd0);
        check("reset_stamp_cycles", {out_stamp, cycles}, 64'd0);
        reset = 1'b0;
    endtask

    task automatic wait_drain();
        out_ready = 1'b1;
        iowrite   = 1'b0;
        finish    = 1'b0;
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) begin
            @(posedge clock);
            #1;
        end
        repeat (2) @(posedge clock);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_done(input bit toggle);
        iowrite = 1'b0;
        finish  = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            out_ready = toggle ? ~out_ready : 1'b1;
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("done_reached", 64'(done), 64'd1);
        check("queue_empty_at_done", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : stimulus
        int rx0;
        int dens;
        n_rx = 0;
        reset = 1'b1;

        // Three writes at cycles 5..7 with the sink always ready.
        do_reset();
        repeat (5) cyc(1'b0, 15'd0, 15'd0, 1'b0, 1'b1);
        rx0 = n_rx;
        cyc(1'b1, 15'd1, 15'd10, 1'b0, 1'b1);
        cyc(1'b1, 15'd2, 15'd20, 1'b0, 1'b1);
        cyc(1'b1, 15'd3, 15'd30, 1'b0, 1'b1);
        wait_drain();
        check("three_records", 64'(n_rx - rx0), 64'd3);

        // Nine writes into a stalled sink: eight kept, one dropped.
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1'b1, 15'(i + 1), 15'(100 + i), 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 15'd0, 15'd0, 1'b0, 1'b0);
        check("overflow_set", 64'(overflow), 64'd1);
        rx0 = n_rx;
        wait_drain();
        check("eight_records", 64'(n_rx - rx0), 64'd8);
        check("overflow_sticky", 64'(overflow), 64'd1);

        // Finish with two queued writes; result drains last.
        do_reset();
        cyc(1'b1, 15'd7, 15'd70, 1'b0, 1'b0);
        cyc(1'b1, 15'd8, 15'd80, 1'b0, 1'b0);
        r = 18'h00055;
        cyc(1'b0, 15'd0, 15'd0, 1'b1, 1'b0);
        r = 18'h3ffff;
        repeat (3) cyc(1'b0, 15'd0, 15'd0, 1'b0, 1'b0);
        rx0 = n_rx;
        wait_done(1'b0);
        check("result_seq_count", 64'(n_rx - rx0), 64'd3);
        check("result_fields", {last_res.kind, last_res.addr, last_res.data},
              {1'b1, 15'd5, 15'd10});

        // Write in the finish cycle is kept; later writes ignored without overflow.
        do_reset();
        cyc(1'b1, 15'd4, 15'd44, 1'b0, 1'b1);
        r = 18'($urandom);
        cyc(1'b1, 15'd5, 15'd55, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) cyc(1'b1, 15'(i), 15'(i), 1'b1, 1'b0);
        rx0 = n_rx;
        wait_done(1'b0);
        check("finish_cycle_records", 64'(n_rx - rx0), 64'd3);
        check("no_overflow_after_finish", 64'(overflow), 64'd0);

        // Random traffic with varying density, then a drain with ready toggling each cycle.
        for (int t = 0; t < 4; t++) begin
            do_reset();
            dens = 20 + 25 * t;
            for (int i = 0; i < 80; i++)
                cyc(1'($urandom_range(0, 99) < dens), 15'($urandom), 15'($urandom),
                    1'b0, 1'($urandom_range(0, 2) == 0));
            r = 18'($urandom);
            cyc(1'($urandom_range(0, 1)), 15'($urandom), 15'($urandom), 1'b1, 1'b0);
            cyc(1'b1, 15'($urandom), 15'($urandom), 1'b1, 1'b1);
            wait_done(1'b1);
        end

        // Reset while draining four queued writes drops everything.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 15'(20 + i), 15'(200 + i), 1'b0, 1'b0);
        cyc(1'b0, 15'd0, 15'd0, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 15'd0, 15'd0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("async_reset_outputs", {out_valid, out_kind, out_addr, out_data, done, overflow},
              64'd0);
        check("async_reset_stamp_cycles", {out_stamp, cycles}, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        rx0 = n_rx;
        repeat (12) cyc(1'b0, 15'd0, 15'd0, 1'b0, 1'b1);
        check("no_records_after_reset", 64'(n_rx - rx0), 64'd0);
        check("not_done_after_reset", 64'(done), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
